// File: rtl/bullet_hit_resolver_pkg.sv
// rtl/bullet_hit_resolver_pkg.sv - shared game constants, position field helpers and resolver FSM states.
package bullet_hit_resolver_pkg;

    localparam int POS_W = 19;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    localparam int MAX_ENEMY         = 15;
    localparam int MAX_PLAYER_BULLET = 15;
    localparam int MAX_ENEMY_BULLET  = 30;

    localparam int HIT_X = 8;
    localparam int HIT_Y = 8;

    localparam int PB_IDX_W   = $clog2(MAX_PLAYER_BULLET);
    localparam int EN_IDX_W   = $clog2(MAX_ENEMY);
    localparam int EB_IDX_W   = $clog2(MAX_ENEMY_BULLET);
    localparam int KILL_CNT_W = $clog2(MAX_ENEMY + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN_PB = 2'd1,
        SCAN_EB = 2'd2,
        REPORT  = 2'd3
    } state_t;

    function automatic logic [X_W-1:0] posX(input logic [POS_W-1:0] pos);
        return pos[POS_W-1:Y_W];
    endfunction

    function automatic logic [Y_W-1:0] posY(input logic [POS_W-1:0] pos);
        return pos[Y_W-1:0];
    endfunction

    function automatic logic [KILL_CNT_W-1:0] countOnes(input logic [MAX_ENEMY-1:0] mask);
        logic [KILL_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_ENEMY; i++) begin
            cnt = cnt + KILL_CNT_W'(mask[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bullet_hit_resolver_hit_box_cmp.sv
// rtl/bullet_hit_resolver_hit_box_cmp.sv - combinational hit-box overlap of two packed positions.
module hit_box_cmp
    import bullet_hit_resolver_pkg::*;
(
    input  logic [POS_W-1:0] posA,
    input  logic [POS_W-1:0] posB,
    output logic             overlap
);

    logic [X_W:0] dx;
    logic [Y_W:0] dy;
    logic [X_W:0] absDx;
    logic [Y_W:0] absDy;

    // One extra bit keeps the sign so coordinates never wrap across the screen edge.
    assign dx = {1'b0, posX(posA)} - {1'b0, posX(posB)};
    assign dy = {1'b0, posY(posA)} - {1'b0, posY(posB)};

    assign absDx = dx[X_W] ? (~dx + 1'b1) : dx;
    assign absDy = dy[Y_W] ? (~dy + 1'b1) : dy;

    assign overlap = (absDx <= (X_W+1)'(HIT_X)) && (absDy <= (Y_W+1)'(HIT_Y));

endmodule

// File: rtl/bullet_hit_resolver.sv
// rtl/bullet_hit_resolver.sv - per-frame bullet/enemy/player collision scan with kill masks and score.
// BULLET_HIT_GODMODE_EN removes the enemy-bullet-vs-player phase.
module bullet_hit_resolver
    import bullet_hit_resolver_pkg::*;
(
    input  logic                               i_Clk,
    input  logic                               i_Rst,
    input  logic                               i_Frame,
    input  logic [MAX_ENEMY-1:0]               i_EnemyState,
    input  logic [MAX_ENEMY*POS_W-1:0]         i_EnemyPos,
    input  logic                               i_PlayerState,
    input  logic [POS_W-1:0]                   i_PlayerPos,
    input  logic [MAX_PLAYER_BULLET-1:0]       i_PlayerBulletState,
    input  logic [MAX_PLAYER_BULLET*POS_W-1:0] i_PlayerBulletPos,
    input  logic [MAX_ENEMY_BULLET-1:0]        i_EnemyBulletState,
    input  logic [MAX_ENEMY_BULLET*POS_W-1:0]  i_EnemyBulletPos,
    output logic                               o_Busy,
    output logic                               o_Done,
    output logic [MAX_ENEMY-1:0]               o_EnemyKill,
    output logic [MAX_PLAYER_BULLET-1:0]       o_PlayerBulletHit,
    output logic [MAX_ENEMY_BULLET-1:0]        o_EnemyBulletHit,
    output logic                               o_PlayerHit,
    output logic [15:0]                        o_Score
);

    localparam logic [PB_IDX_W-1:0] PB_LAST = PB_IDX_W'(MAX_PLAYER_BULLET - 1);
    localparam logic [EN_IDX_W-1:0] EN_LAST = EN_IDX_W'(MAX_ENEMY - 1);

    state_t                       state;
    logic [PB_IDX_W-1:0]          pIdx;
    logic [EN_IDX_W-1:0]          eIdx;
    logic [MAX_ENEMY-1:0]         killAcc;
    logic [MAX_PLAYER_BULLET-1:0] pbAcc;
    logic [MAX_ENEMY-1:0]         killNext;
    logic [MAX_PLAYER_BULLET-1:0] pbNext;

    logic [POS_W-1:0] enemyPosArr  [MAX_ENEMY];
    logic [POS_W-1:0] pBulletPosArr[MAX_PLAYER_BULLET];

    logic [POS_W-1:0] cmpA;
    logic [POS_W-1:0] cmpB;
    logic             overlap;
    logic             pbHit;

    logic [16:0]      scoreSum;

    for (genvar i = 0; i < MAX_ENEMY; i++) begin : g_enemyPos
        assign enemyPosArr[i] = i_EnemyPos[i*POS_W +: POS_W];
    end

    for (genvar i = 0; i < MAX_PLAYER_BULLET; i++) begin : g_pBulletPos
        assign pBulletPosArr[i] = i_PlayerBulletPos[i*POS_W +: POS_W];
    end

`ifndef BULLET_HIT_GODMODE_EN
    localparam logic [EB_IDX_W-1:0] EB_LAST = EB_IDX_W'(MAX_ENEMY_BULLET - 1);

    logic [EB_IDX_W-1:0]         bIdx;
    logic [MAX_ENEMY_BULLET-1:0] ebAcc;
    logic [MAX_ENEMY_BULLET-1:0] ebNext;
    logic                        phAcc;
    logic                        phNext;
    logic                        ebHit;
    logic [POS_W-1:0]            eBulletPosArr[MAX_ENEMY_BULLET];

    for (genvar i = 0; i < MAX_ENEMY_BULLET; i++) begin : g_eBulletPos
        assign eBulletPosArr[i] = i_EnemyBulletPos[i*POS_W +: POS_W];
    end

    // The single comparator is time-shared: bullet/enemy pairs first, then bullet/player.
    assign cmpA = (state == SCAN_EB) ? eBulletPosArr[bIdx] : pBulletPosArr[pIdx];
    assign cmpB = (state == SCAN_EB) ? i_PlayerPos         : enemyPosArr[eIdx];

    assign ebHit = (state == SCAN_EB) && i_EnemyBulletState[bIdx] && i_PlayerState && overlap;

    always_comb begin
        ebNext = ebAcc;
        phNext = phAcc | ebHit;
        if (ebHit) begin
            ebNext[bIdx] = 1'b1;
        end
    end
`else
    assign cmpA = pBulletPosArr[pIdx];
    assign cmpB = enemyPosArr[eIdx];

    assign o_PlayerHit      = 1'b0;
    assign o_EnemyBulletHit = '0;
`endif

    hit_box_cmp u_hitBoxCmp (
        .posA    (cmpA),
        .posB    (cmpB),
        .overlap (overlap)
    );

    // Already-consumed bullets and already-killed enemies drop out, so lowest index wins both ways.
    assign pbHit = (state == SCAN_PB) && i_PlayerBulletState[pIdx] && i_EnemyState[eIdx] &&
                   !pbAcc[pIdx] && !killAcc[eIdx] && overlap;

    always_comb begin
        killNext = killAcc;
        pbNext   = pbAcc;
        if (pbHit) begin
            killNext[eIdx] = 1'b1;
            pbNext[pIdx]   = 1'b1;
        end
    end

    assign scoreSum = {1'b0, o_Score} + 17'(countOnes(o_EnemyKill));

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state             <= IDLE;
            pIdx              <= '0;
            eIdx              <= '0;
            killAcc           <= '0;
            pbAcc             <= '0;
            o_Busy            <= 1'b0;
            o_Done            <= 1'b0;
            o_EnemyKill       <= '0;
            o_PlayerBulletHit <= '0;
            o_Score           <= '0;
`ifndef BULLET_HIT_GODMODE_EN
            bIdx              <= '0;
            ebAcc             <= '0;
            phAcc             <= 1'b0;
            o_EnemyBulletHit  <= '0;
            o_PlayerHit       <= 1'b0;
`endif
        end else begin
            o_Done            <= 1'b0;
            o_EnemyKill       <= '0;
            o_PlayerBulletHit <= '0;
`ifndef BULLET_HIT_GODMODE_EN
            o_EnemyBulletHit  <= '0;
            o_PlayerHit       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (i_Frame) begin
                        state   <= SCAN_PB;
                        pIdx    <= '0;
                        eIdx    <= '0;
                        killAcc <= '0;
                        pbAcc   <= '0;
                        o_Busy  <= 1'b1;
`ifndef BULLET_HIT_GODMODE_EN
                        bIdx    <= '0;
                        ebAcc   <= '0;
                        phAcc   <= 1'b0;
`endif
                    end
                end
                SCAN_PB: begin
                    killAcc <= killNext;
                    pbAcc   <= pbNext;
                    if (eIdx == EN_LAST) begin
                        eIdx <= '0;
                        if (pIdx == PB_LAST) begin
`ifdef BULLET_HIT_GODMODE_EN
                            state             <= REPORT;
                            o_Done            <= 1'b1;
                            o_EnemyKill       <= killNext;
                            o_PlayerBulletHit <= pbNext;
`else
                            state <= SCAN_EB;
                            bIdx  <= '0;
`endif
                        end else begin
                            pIdx <= pIdx + 1'b1;
                        end
                    end else begin
                        eIdx <= eIdx + 1'b1;
                    end
                end
`ifndef BULLET_HIT_GODMODE_EN
                SCAN_EB: begin
                    ebAcc <= ebNext;
                    phAcc <= phNext;
                    if (bIdx == EB_LAST) begin
                        state             <= REPORT;
                        o_Done            <= 1'b1;
                        o_EnemyKill       <= killAcc;
                        o_PlayerBulletHit <= pbAcc;
                        o_EnemyBulletHit  <= ebNext;
                        o_PlayerHit       <= phNext;
                    end else begin
                        bIdx <= bIdx + 1'b1;
                    end
                end
`endif
                REPORT: begin
                    state   <= IDLE;
                    o_Busy  <= 1'b0;
                    o_Score <= scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
                end
                default: begin
                    state  <= IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_hit_resolver.sv
// tb/tb_bullet_hit_resolver.sv - scoreboard bench with directed and random frames against a reference model.
module tb_bullet_hit_resolver;
    import bullet_hit_resolver_pkg::*;

    localparam int N = MAX_PLAYER_BULLET * MAX_ENEMY;
`ifdef BULLET_HIT_GODMODE_EN
    localparam int LAT = N;
`else
    localparam int LAT = N + MAX_ENEMY_BULLET;
`endif

    logic                               clk = 1'b0;
    logic                               rstN = 1'b0;
    logic                               frame = 1'b0;
    logic [MAX_ENEMY-1:0]               enState = '0;
    logic [MAX_ENEMY*POS_W-1:0]         enPos = '0;
    logic                               plState = 1'b0;
    logic [POS_W-1:0]                   plPos = '0;
    logic [MAX_PLAYER_BULLET-1:0]       pbState = '0;
    logic [MAX_PLAYER_BULLET*POS_W-1:0] pbPos = '0;
    logic [MAX_ENEMY_BULLET-1:0]        ebState = '0;
    logic [MAX_ENEMY_BULLET*POS_W-1:0]  ebPos = '0;
    logic                               busy, done, playerHit;
    logic [MAX_ENEMY-1:0]               enemyKill;
    logic [MAX_PLAYER_BULLET-1:0]       pbHit;
    logic [MAX_ENEMY_BULLET-1:0]        ebHit;
    logic [15:0]                        score;

    bullet_hit_resolver dut (
        .i_Clk               (clk),
        .i_Rst               (rstN),
        .i_Frame             (frame),
        .i_EnemyState        (enState),
        .i_EnemyPos          (enPos),
        .i_PlayerState       (plState),
        .i_PlayerPos         (plPos),
        .i_PlayerBulletState (pbState),
        .i_PlayerBulletPos   (pbPos),
        .i_EnemyBulletState  (ebState),
        .i_EnemyBulletPos    (ebPos),
        .o_Busy              (busy),
        .o_Done              (done),
        .o_EnemyKill         (enemyKill),
        .o_PlayerBulletHit   (pbHit),
        .o_EnemyBulletHit    (ebHit),
        .o_PlayerHit         (playerHit),
        .o_Score             (score)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    int enX[MAX_ENEMY], enY[MAX_ENEMY];
    int pbX[MAX_PLAYER_BULLET], pbY[MAX_PLAYER_BULLET];
    int ebX[MAX_ENEMY_BULLET], ebY[MAX_ENEMY_BULLET];
    int plX, plY;
    int scoreModel = 0;

    typedef struct {
        logic [MAX_ENEMY-1:0]         kill;
        logic [MAX_PLAYER_BULLET-1:0] pb;
        logic [MAX_ENEMY_BULLET-1:0]  eb;
        logic                         ph;
        logic [15:0]                  score;
        int                           doneCyc;
    } exp_t;

    exp_t expQ[$];

    function automatic bit near(input int ax, input int ay, input int bx, input int by);
        int dx, dy;
        dx = ax - bx; if (dx < 0) dx = -dx;
        dy = ay - by; if (dy < 0) dy = -dy;
        return (dx <= HIT_X) && (dy <= HIT_Y);
    endfunction

    task automatic modelFrame(output exp_t ex);
        int kills;
        ex.kill = '0; ex.pb = '0; ex.eb = '0; ex.ph = 1'b0; ex.doneCyc = 0;
        for (int p = 0; p < MAX_PLAYER_BULLET; p++)
            for (int e = 0; e < MAX_ENEMY; e++)
                if (pbState[p] && enState[e] && !ex.pb[p] && !ex.kill[e] &&
                    near(pbX[p], pbY[p], enX[e], enY[e])) begin
                    ex.pb[p] = 1'b1;
                    ex.kill[e] = 1'b1;
                end
`ifndef BULLET_HIT_GODMODE_EN
        for (int b = 0; b < MAX_ENEMY_BULLET; b++)
            if (ebState[b] && plState && near(ebX[b], ebY[b], plX, plY)) begin
                ex.eb[b] = 1'b1;
                ex.ph = 1'b1;
            end
`endif
        kills = $countones(ex.kill);
        scoreModel = (scoreModel + kills > 65535) ? 65535 : scoreModel + kills;
        ex.score = 16'(scoreModel);
    endtask

    task automatic driveInputs();
        for (int e = 0; e < MAX_ENEMY; e++) enPos[e*POS_W +: POS_W] = {10'(enX[e]), 9'(enY[e])};
        for (int p = 0; p < MAX_PLAYER_BULLET; p++) pbPos[p*POS_W +: POS_W] = {10'(pbX[p]), 9'(pbY[p])};
        for (int b = 0; b < MAX_ENEMY_BULLET; b++) ebPos[b*POS_W +: POS_W] = {10'(ebX[b]), 9'(ebY[b])};
        plPos = {10'(plX), 9'(plY)};
    endtask

    task automatic clearAll();
        enState = '0; pbState = '0; ebState = '0; plState = 1'b0;
        plX = 0; plY = 0;
        for (int e = 0; e < MAX_ENEMY; e++) begin enX[e] = 0; enY[e] = 0; end
        for (int p = 0; p < MAX_PLAYER_BULLET; p++) begin pbX[p] = 0; pbY[p] = 0; end
        for (int b = 0; b < MAX_ENEMY_BULLET; b++) begin ebX[b] = 0; ebY[b] = 0; end
    endtask

    task automatic runFrame(input bit midPulse);
        exp_t ex;
        int k;
        driveInputs();
        modelFrame(ex);
        @(negedge clk);
        frame = 1'b1;
        k = cyc + 1;
        ex.doneCyc = k + LAT;
        expQ.push_back(ex);
        @(negedge clk);
        frame = 1'b0;
        check("busy_start", busy, 1'b1);
        if (midPulse) begin
            repeat (49) @(negedge clk);
            frame = 1'b1;
            @(negedge clk);
            frame = 1'b0;
        end
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        check("busy_drop_cycle", 64'(cyc), 64'(k + LAT + 1));
    endtask

    initial begin : monitor
        exp_t cur;
        forever begin
            @(negedge clk);
            if (done) begin
                if (expQ.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    cur = expQ.pop_front();
                    check("done_cycle", 64'(cyc), 64'(cur.doneCyc));
                    check("enemy_kill", enemyKill, cur.kill);
                    check("pbullet_hit", pbHit, cur.pb);
                    check("ebullet_hit", ebHit, cur.eb);
                    check("player_hit", playerHit, cur.ph);
                    check("busy_in_report", busy, 1'b1);
                    @(negedge clk);
                    check("score", score, cur.score);
                    check("done_one_cycle", done, 1'b0);
                end
            end else begin
                check("masks_idle", {enemyKill, pbHit, ebHit, playerHit}, '0);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        clearAll();
        driveInputs();
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, enemyKill, pbHit, ebHit, playerHit, score}, '0);
        rstN = 1'b1;
        @(negedge clk);

        // basic hit
        clearAll();
        pbState[0] = 1'b1; pbX[0] = 320; pbY[0] = 100;
        enState[0] = 1'b1; enX[0] = 324; enY[0] = 104;
        runFrame(1'b0);

        // box corner still hits, one pixel further does not
        enX[0] = 328; enY[0] = 108;
        runFrame(1'b0);
        enX[0] = 329; enY[0] = 100;
        runFrame(1'b0);

        // two bullets on one enemy: lowest bullet wins
        clearAll();
        enState[5] = 1'b1; enX[5] = 200; enY[5] = 200;
        pbState[0] = 1'b1; pbX[0] = 205; pbY[0] = 195;
        pbState[3] = 1'b1; pbX[3] = 200; pbY[3] = 200;
        runFrame(1'b0);

        // enemy bullet on player, alive and dead
        clearAll();
        plState = 1'b1; plX = 400; plY = 300;
        ebState[7] = 1'b1; ebX[7] = 400; ebY[7] = 300;
        runFrame(1'b0);
        plState = 1'b0;
        runFrame(1'b0);

        // screen edges never wrap
        clearAll();
        pbState[0] = 1'b1; pbX[0] = 0;    pbY[0] = 0;
        enState[0] = 1'b1; enX[0] = 1023; enY[0] = 511;
        pbState[1] = 1'b1; pbX[1] = 1023; pbY[1] = 0;
        enState[1] = 1'b1; enX[1] = 1020; enY[1] = 5;
        runFrame(1'b0);

        // reset mid-scan: no done, everything cleared
        clearAll();
        pbState[0] = 1'b1; pbX[0] = 320; pbY[0] = 100;
        enState[0] = 1'b1; enX[0] = 324; enY[0] = 104;
        driveInputs();
        @(negedge clk); frame = 1'b1;
        @(negedge clk); frame = 1'b0;
        repeat (99) @(negedge clk);
        rstN = 1'b0;
        scoreModel = 0;
        @(negedge clk);
        check("midscan_reset", {busy, done, enemyKill, pbHit, ebHit, playerHit, score}, '0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (300) @(negedge clk);
        check("no_done_after_reset", 64'(expQ.size()), 0);

        // fresh frame, then a frame with a stray strobe mid-scan
        runFrame(1'b0);
        runFrame(1'b1);

        // random frames clustered so collisions are common
        for (int r = 0; r < 12; r++) begin
            clearAll();
            enState = MAX_ENEMY'($urandom);
            pbState = MAX_PLAYER_BULLET'($urandom);
            ebState = MAX_ENEMY_BULLET'($urandom);
            plState = 1'($urandom);
            plX = 300 + $urandom_range(0, 40); plY = 100 + $urandom_range(0, 40);
            for (int e = 0; e < MAX_ENEMY; e++) begin
                enX[e] = 300 + $urandom_range(0, 40); enY[e] = 100 + $urandom_range(0, 40);
            end
            for (int p = 0; p < MAX_PLAYER_BULLET; p++) begin
                pbX[p] = 300 + $urandom_range(0, 40); pbY[p] = 100 + $urandom_range(0, 40);
            end
            for (int b = 0; b < MAX_ENEMY_BULLET; b++) begin
                ebX[b] = 300 + $urandom_range(0, 40); ebY[b] = 100 + $urandom_range(0, 40);
            end
            runFrame(1'b0);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(expQ.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
